// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each granted access takes three cycles: IDLE (grant), ACCESS (memory strobe), DONE (ack).
module data_mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              memwr,
    output logic              memrd,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wrdata,
    input  logic [DATA_W-1:0] rddata,
    output logic              busy,
    output logic              gnt_id
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                memwr_q, memwr_d;
    logic                memrd_q, memrd_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                busy_q, busy_d;
    logic                sel;

    // Under contention the port that did not win last time is chosen.
    assign sel = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        memwr_d  = 1'b0;
        memrd_d  = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = StAccess;
                    last_d  = sel;
                    gnt_d   = sel;
                    addr_d  = sel ? addr1 : addr0;
                    wdata_d = sel ? wdata1 : wdata0;
                    memwr_d = sel ? we1 : we0;
                    memrd_d = sel ? ~we1 : ~we0;
                end
            end
            StAccess: begin
                state_d = StDone;
                if (memrd_q) begin
                    if (gnt_q) rdata1_d = rddata;
                    else       rdata0_d = rddata;
                end
                ack0_d = ~gnt_q;
                ack1_d = gnt_q;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            memwr_q  <= 1'b0;
            memrd_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            memwr_q  <= memwr_d;
            memrd_q  <= memrd_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign memwr   = memwr_q;
    assign memrd   = memrd_q;
    assign address = addr_q;
    assign wrdata  = wdata_q;
    assign busy    = busy_q;
    assign gnt_id  = gnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios then random traffic, all checked every
// cycle against a transaction-timeline model and a private memory image.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        memwr, memrd;
    logic [7:0]  address;
    logic [31:0] wrdata;
    logic [31:0] rddata;
    logic        busy, gnt_id;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .memwr(memwr), .memrd(memrd), .address(address), .wrdata(wrdata),
        .rddata(rddata), .busy(busy), .gnt_id(gnt_id)
    );

    // Memory attached to the DUT; a garbage value when not read exposes stray captures.
    logic [31:0] tmem [256];
    always @(posedge clk) if (memwr) tmem[address] <= wrdata;
    assign rddata = memrd ? tmem[address] : 32'hBAD0_BAD0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: a grant sampled at cycle g yields the memory strobe in g+1, the ack
    // in g+2, and the next grant may be sampled at g+3.
    logic [31:0] mmem [256];
    int          cyc = 0;
    int          g = -100;
    logic        m_last, m_port, m_we;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic        e_memwr, e_memrd, e_ack0, e_ack1, e_busy, e_gnt;
    logic [7:0]  e_address;
    logic [31:0] e_wrdata, e_rdata0, e_rdata1;

    task automatic model_update();
        if (rst) begin
            if (cyc == g + 1 && m_we) mmem[m_addr] = m_wdata;
            g = cyc - 2;
            m_last = 1'b1;
            e_memwr = 0; e_memrd = 0; e_ack0 = 0; e_ack1 = 0; e_busy = 0; e_gnt = 0;
            e_address = 0; e_wrdata = 0; e_rdata0 = 0; e_rdata1 = 0;
        end else begin
            e_memwr = 0; e_memrd = 0; e_ack0 = 0; e_ack1 = 0;
            if (cyc == g + 1) begin
                if (m_we) mmem[m_addr] = m_wdata;
                else if (m_port) e_rdata1 = mmem[m_addr];
                else e_rdata0 = mmem[m_addr];
                e_ack0 = !m_port;
                e_ack1 = m_port;
                e_busy = 1;
            end else if (cyc >= g + 3 && (req0 || req1)) begin
                m_port  = (req0 && req1) ? !m_last : req1;
                m_last  = m_port;
                g       = cyc;
                m_we    = m_port ? we1 : we0;
                m_addr  = m_port ? addr1 : addr0;
                m_wdata = m_port ? wdata1 : wdata0;
                e_gnt     = m_port;
                e_memwr   = m_we;
                e_memrd   = !m_we;
                e_address = m_addr;
                e_wrdata  = m_wdata;
                e_busy    = 1;
            end else begin
                e_busy = 0;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("memwr",   32'(memwr),   32'(e_memwr));
        check("memrd",   32'(memrd),   32'(e_memrd));
        check("ack0",    32'(ack0),    32'(e_ack0));
        check("ack1",    32'(ack1),    32'(e_ack1));
        check("busy",    32'(busy),    32'(e_busy));
        check("gnt_id",  32'(gnt_id),  32'(e_gnt));
        check("address", 32'(address), 32'(e_address));
        check("wrdata",  wrdata,       e_wrdata);
        check("rdata0",  rdata0,       e_rdata0);
        check("rdata1",  rdata1,       e_rdata1);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    logic pend0, pend1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            tmem[i] = 0;
            mmem[i] = 0;
        end
        m_last = 1; m_port = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        do_reset();
        do_reset();

        // Single write from port 0.
        req0 = 1; we0 = 1; addr0 = 8'h05; wdata0 = 32'hDEAD_BEEF;
        step();
        check("wr_strobe", 32'({memwr, memrd, address}), 32'({1'b1, 1'b0, 8'h05}));
        step();
        check("wr_ack0", 32'({ack0, ack1}), 32'b10);
        req0 = 0;
        step();

        // Read-back from port 1.
        req1 = 1; we1 = 0; addr1 = 8'h05;
        step();
        check("rd_strobe", 32'({memwr, memrd}), 32'b01);
        step();
        check("rd_data1", rdata1, 32'hDEAD_BEEF);
        check("rd_data0", rdata0, 32'h0);
        req1 = 0;
        step();

        // Contention from reset: expected grant order 0,1,0,1.
        do_reset();
        req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 32'h1111_0000;
        req1 = 1; we1 = 1; addr1 = 8'h31; wdata1 = 32'h2222_0000;
        for (int k = 0; k < 4; k++) begin
            step();
            check("cont_gnt", 32'(gnt_id), 32'(k % 2));
            step();
            step();
        end
        req0 = 0; req1 = 0;
        step(); step(); step();

        // Reset during ACCESS of a port-1 read aborts with no ack.
        req1 = 1; we1 = 0; addr1 = 8'h30;
        step();
        check("abort_acc", 32'(memrd), 32'd1);
        rst = 1;
        step();
        rst = 0; req1 = 0;
        check("abort_ack", 32'({ack1, busy}), 32'd0);
        step();

        // Address change after grant is ignored.
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 32'hCAFE_0010;
        step();
        addr0 = 8'h20;
        check("hold_addr_a", 32'(address), 32'h10);
        step();
        check("hold_addr_d", 32'(address), 32'h10);
        req0 = 0;
        step();

        // Idle for 10 cycles.
        for (int k = 0; k < 10; k++) step();
        check("idle_addr", 32'(address), 32'h10);

        // Random traffic with requesters that hold until ack.
        pend0 = 0; pend1 = 0;
        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (ack0) pend0 = 0;
            if (ack1) pend1 = 0;
            if (!pend0) begin
                if ($urandom_range(0, 2) == 0) begin
                    pend0 = 1; req0 = 1; we0 = 1'($urandom_range(0, 1));
                    addr0 = 8'($urandom_range(0, 7)); wdata0 = $urandom;
                end else req0 = 0;
            end
            if (!pend1) begin
                if ($urandom_range(0, 2) == 0) begin
                    pend1 = 1; req1 = 1; we1 = 1'($urandom_range(0, 1));
                    addr1 = 8'($urandom_range(0, 7)); wdata1 = $urandom;
                end else req1 = 0;
            end
            step();
            if (rst) begin
                pend0 = 0;
                pend1 = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
